mem_port_arbiter: RTL and testbench

Sequential arbiter that shares one single-port unified memory between the core's instruction-fetch requester and its load/store requester. It accepts requests over a req/gnt handshake, issues exactly one memory access at a time on the shared port, waits a fixed memory latency, and returns read data or write completion to the requester that owns the transaction. It sits between the core datapath (program counter / fetch path, ALU-addressed data path) and the shared memory, replacing separate instruction and data memories.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
// ----------------------------------------------------------------------------
// Shares one single-port unified memory between the instruction-fetch
// requester and the load/store requester. Requests are accepted over a
// req/gnt handshake, exactly one access is in flight at a time, the memory
// answers after a fixed latency, and the result is returned to the owner.
//
// Parameters
//   MEM_LAT    cycles from the mem_en cycle to the cycle mem_rdata is valid
//              (legal range 1..7, held in a 3-bit counter)
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   if_req/if_addr      fetch request and byte address (held until if_gnt)
//   if_gnt              one-cycle grant pulse to fetch
//   if_rvalid/if_rdata  fetch completion pulse / read data (held)
//   d_req/d_we/d_addr/d_wdata  data request, byte enables (0 = read),
//                       address and store data (held until d_gnt)
//   d_gnt               one-cycle grant pulse to data
//   d_rvalid/d_rdata    data completion pulse (reads and writes) / load data
//   mem_en/mem_we       memory strobe (one cycle) and byte enables
//   mem_addr/mem_wdata  registered access address and write data
//   mem_rdata           memory read data
//   busy                high whenever the FSM is not IDLE
// ============================================================================
module mem_port_arbiter #(
   parameter int unsigned MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic [3:0]  d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        mem_en,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        last_data_q;   // 1: data won the most recent grant
   logic        owner_data_q;  // 1: in-flight transaction belongs to data
   logic [2:0]  cnt_q;
   logic [3:0]  we_q;

   logic        grant_ok;
   logic        win_data;
   logic        grant_if;
   logic        grant_d;

   // Grant decision and next state.
   // NOTE: every signal assigned in this block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      grant_ok = 1'b0;
      win_data = 1'b0;
      grant_if = 1'b0;
      grant_d  = 1'b0;
      state_d  = state_q;

      grant_ok = (state_q == IDLE) || (state_q == RESP);
      // Round-robin: on a tie the requester that did not win last time wins.
      win_data = d_req && (!if_req || !last_data_q);
      grant_d  = grant_ok && win_data;
      grant_if = grant_ok && if_req && !win_data;

      case (state_q)
         IDLE:    if (grant_if || grant_d) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (cnt_q == 3'd1) state_d = RESP;
         RESP:    state_d = (grant_if || grant_d) ? ISSUE : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The FSM sits in IDLE during reset, where the grant logic is live; gating
   // with rst keeps the grants at 0 while reset is asserted.
   assign if_gnt    = grant_if && rst;
   assign d_gnt     = grant_d && rst;
   assign mem_en    = (state_q == ISSUE);
   // The captured enables are only exposed during the strobe cycle.
   assign mem_we    = mem_en ? we_q : 4'b0000;
   assign if_rvalid = (state_q == RESP) && !owner_data_q;
   assign d_rvalid  = (state_q == RESP) && owner_data_q;
   assign busy      = (state_q != IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: every register here, including the data-holding ones, is reset
      // because their values are architecturally visible outputs.
      if (!rst) begin
         state_q      <= IDLE;
         last_data_q  <= 1'b1;
         owner_data_q <= 1'b0;
         cnt_q        <= 3'd0;
         we_q         <= 4'b0000;
         mem_addr     <= 32'd0;
         mem_wdata    <= 32'd0;
         if_rdata     <= 32'd0;
         d_rdata      <= 32'd0;
      end else begin
         state_q <= state_d;

         if (grant_if || grant_d) begin
            owner_data_q <= grant_d;
            last_data_q  <= grant_d;
            mem_addr     <= grant_d ? d_addr : if_addr;
            we_q         <= grant_d ? d_we : 4'b0000;
            mem_wdata    <= grant_d ? d_wdata : 32'd0;
         end

         if (state_q == ISSUE) begin
            cnt_q <= 3'(MEM_LAT);
         end else if (state_q == WAIT) begin
            cnt_q <= cnt_q - 3'd1;
            // Last WAIT cycle: memory data is valid now. Writes leave the
            // owner's read register untouched.
            if (cnt_q == 3'd1 && we_q == 4'b0000) begin
               if (owner_data_q) d_rdata  <= mem_rdata;
               else              if_rdata <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for mem_port_arbiter. A transaction-level reference
// model (one outstanding transaction with its grant cycle, a round-robin
// "last winner" bit and a word-addressed memory array) predicts every output
// in every cycle. Directed scenarios are followed by randomized traffic.
// ============================================================================
module tb_mem_port_arbiter;

   localparam int LAT      = 3;
   localparam int RESP_OFS = LAT + 2;  // grant cycle -> rvalid cycle

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req;
   logic [3:0]  d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;

   mem_port_arbiter #(.MEM_LAT(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- next-cycle stimulus ----------------
   logic        n_if_req   = 1'b0;
   logic [31:0] n_if_addr  = 32'd0;
   logic        n_d_req    = 1'b0;
   logic [3:0]  n_d_we     = 4'd0;
   logic [31:0] n_d_addr   = 32'd0;
   logic [31:0] n_d_wdata  = 32'd0;
   bit          rand_mode  = 1'b0;

   // ---------------- reference model ----------------
   int          cyc = 0;
   bit          tv;            // a transaction is outstanding
   int          tg;            // its grant cycle
   bit          t_data;        // owned by data
   logic [3:0]  t_we;
   logic [31:0] t_addr, t_wdata, t_rdata;
   bit          last_data;
   logic [31:0] exp_if_rdata, exp_d_rdata;
   logic [31:0] mem_arr [int];
   bit          pend_v;
   int          pend_cyc;
   logic [31:0] pend_data;
   int          gq_cyc  [$];   // observed grants (cycle, owner)
   bit          gq_data [$];

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      int k;
      k = int'(a[31:2]);
      if (mem_arr.exists(k)) return mem_arr[k];
      return a ^ 32'hA5C3_0F96;
   endfunction

   task automatic mem_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
      logic [31:0] cur;
      cur = mem_read(a);
      for (int b = 0; b < 4; b++)
         if (we[b]) cur[8*b +: 8] = wd[8*b +: 8];
      mem_arr[int'(a[31:2])] = cur;
   endtask

   task automatic model_reset();
      tv           = 1'b0;
      last_data    = 1'b1;
      exp_if_rdata = 32'd0;
      exp_d_rdata  = 32'd0;
      pend_v       = 1'b0;
   endtask

   task automatic sample_and_check();
      bit          ex_busy, ex_en, ex_ifv, ex_dv, free, win_d, ex_ifg, ex_dg;
      logic [3:0]  ex_we;
      ex_busy = tv;
      ex_en   = tv && (cyc == tg + 1);
      ex_we   = ex_en ? t_we : 4'd0;
      if (ex_en) begin
         t_rdata = mem_read(t_addr);
         if (t_we != 4'd0) mem_write(t_addr, t_we, t_wdata);
      end
      ex_ifv = tv && (cyc == tg + RESP_OFS) && !t_data;
      ex_dv  = tv && (cyc == tg + RESP_OFS) && t_data;
      if (ex_ifv) exp_if_rdata = t_rdata;
      if (ex_dv && t_we == 4'd0) exp_d_rdata = t_rdata;
      free   = !tv || (cyc == tg + RESP_OFS);
      win_d  = d_req && (!if_req || !last_data);
      ex_dg  = free && win_d;
      ex_ifg = free && if_req && !win_d;

      check("if_gnt",    if_gnt,    ex_ifg);
      check("d_gnt",     d_gnt,     ex_dg);
      check("mem_en",    mem_en,    ex_en);
      check("mem_we",    mem_we,    ex_we);
      if (ex_en) begin
         check("mem_addr",  mem_addr,  t_addr);
         check("mem_wdata", mem_wdata, t_wdata);
      end
      check("if_rvalid", if_rvalid, ex_ifv);
      check("d_rvalid",  d_rvalid,  ex_dv);
      check("if_rdata",  if_rdata,  exp_if_rdata);
      check("d_rdata",   d_rdata,   exp_d_rdata);
      check("busy",      busy,      ex_busy);

      if (if_gnt || d_gnt) begin
         gq_cyc.push_back(cyc);
         gq_data.push_back(d_gnt);
      end

      if (ex_ifg || ex_dg) begin
         tv        = 1'b1;
         tg        = cyc;
         t_data    = ex_dg;
         t_addr    = ex_dg ? d_addr : if_addr;
         t_we      = ex_dg ? d_we : 4'd0;
         t_wdata   = ex_dg ? d_wdata : 32'd0;
         last_data = ex_dg;
      end else if (free) begin
         tv = 1'b0;
      end

      // Memory responder: data is valid only in the cycle LAT after mem_en.
      if (mem_en) begin
         pend_v    = 1'b1;
         pend_cyc  = cyc + LAT;
         pend_data = mem_read(mem_addr);
      end
   endtask

   task automatic gen_next();
      if (!n_if_req || if_gnt) begin
         n_if_req  = ($urandom_range(0, 3) != 0);
         n_if_addr = 32'h100 + ($urandom_range(0, 15) << 2);
      end
      if (!n_d_req || d_gnt) begin
         n_d_req   = ($urandom_range(0, 3) != 0);
         n_d_we    = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
         n_d_addr  = 32'h100 + ($urandom_range(0, 15) << 2);
         n_d_wdata = $urandom;
      end
   endtask

   // One clock cycle: drive after the edge, sample once everything settles.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if_req    = n_if_req;
      if_addr   = n_if_addr;
      d_req     = n_d_req;
      d_we      = n_d_we;
      d_addr    = n_d_addr;
      d_wdata   = n_d_wdata;
      mem_rdata = (pend_v && cyc == pend_cyc) ? pend_data : $urandom;
      #1;
      sample_and_check();
      if (rand_mode) gen_next();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_if_gnt"},    if_gnt,    1'b0);
      check({tag, "_d_gnt"},     d_gnt,     1'b0);
      check({tag, "_if_rvalid"}, if_rvalid, 1'b0);
      check({tag, "_d_rvalid"},  d_rvalid,  1'b0);
      check({tag, "_mem_en"},    mem_en,    1'b0);
      check({tag, "_busy"},      busy,      1'b0);
      check({tag, "_mem_we"},    mem_we,    4'd0);
      check({tag, "_mem_addr"},  mem_addr,  32'd0);
      check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      check({tag, "_if_rdata"},  if_rdata,  32'd0);
      check({tag, "_d_rdata"},   d_rdata,   32'd0);
   endtask

   // Asserted between edges; outputs must clear without a clock.
   task automatic do_reset(input string tag);
      rst    = 1'b0;
      if_req = 1'b1;
      d_req  = 1'b1;
      #1;
      check_zero(tag);
      repeat (2) @(posedge clk);
      #3;
      if_req   = 1'b0;
      d_req    = 1'b0;
      n_if_req = 1'b0;
      n_d_req  = 1'b0;
      rst      = 1'b1;
      model_reset();
   endtask

   task automatic drain();
      n_if_req = 1'b0;
      n_d_req  = 1'b0;
      repeat (RESP_OFS + 1) step();
   endtask

   initial begin
      int          c0;
      logic [31:0] prev;
      rst       = 1'b0;
      if_req    = 1'b0;
      if_addr   = 32'd0;
      d_req     = 1'b0;
      d_we      = 4'd0;
      d_addr    = 32'd0;
      d_wdata   = 32'd0;
      mem_rdata = 32'd0;
      model_reset();
      #2;
      check_zero("por");
      do_reset("rst_init");

      // Single fetch.
      mem_arr[int'(32'h10 >> 2)] = 32'h0050_0093;
      n_if_req  = 1'b1;
      n_if_addr = 32'h10;
      step();
      check("sf_gnt", if_gnt, 1'b1);
      n_if_req = 1'b0;
      step();
      check("sf_mem_en", mem_en, 1'b1);
      check("sf_mem_addr", mem_addr, 32'h10);
      repeat (RESP_OFS - 1) step();
      check("sf_rvalid", if_rvalid, 1'b1);
      check("sf_rdata", if_rdata, 32'h0050_0093);
      check("sf_d_rvalid", d_rvalid, 1'b0);
      step();

      // Data write, then read it back.
      prev      = d_rdata;
      n_d_req   = 1'b1;
      n_d_we    = 4'b1111;
      n_d_addr  = 32'h100;
      n_d_wdata = 32'hDEAD_BEEF;
      step();
      check("dw_gnt", d_gnt, 1'b1);
      n_d_req = 1'b0;
      step();
      check("dw_mem_we", mem_we, 4'b1111);
      check("dw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      repeat (RESP_OFS - 1) step();
      check("dw_rvalid", d_rvalid, 1'b1);
      check("dw_rdata_kept", d_rdata, prev);
      n_d_req = 1'b1;
      n_d_we  = 4'b0000;
      step();
      n_d_req = 1'b0;
      repeat (RESP_OFS) step();
      check("dr_rdata", d_rdata, 32'hDEAD_BEEF);
      step();

      // Tie after reset, both held: F, D, F at RESP_OFS spacing.
      do_reset("rst_tie");
      gq_cyc.delete();
      gq_data.delete();
      n_if_req  = 1'b1;
      n_if_addr = 32'h44;
      n_d_req   = 1'b1;
      n_d_we    = 4'b0000;
      n_d_addr  = 32'h48;
      step();
      c0 = cyc;
      repeat (2 * RESP_OFS) step();
      drain();
      check("tie_count", 32'(gq_cyc.size() >= 3), 32'd1);
      if (gq_cyc.size() >= 3) begin
         check("tie0_cyc", gq_cyc[0], c0);
         check("tie0_own", gq_data[0], 1'b0);
         check("tie1_cyc", gq_cyc[1], c0 + RESP_OFS);
         check("tie1_own", gq_data[1], 1'b1);
         check("tie2_cyc", gq_cyc[2], c0 + 2 * RESP_OFS);
         check("tie2_own", gq_data[2], 1'b0);
      end

      // Data read with a fetch arriving behind it.
      mem_arr[int'(32'h200 >> 2)] = 32'hCAFE_F00D;
      n_d_req  = 1'b1;
      n_d_we   = 4'b0000;
      n_d_addr = 32'h200;
      step();
      n_d_req   = 1'b0;
      n_if_req  = 1'b1;
      n_if_addr = 32'h40;
      repeat (RESP_OFS) step();
      check("rd_rvalid", d_rvalid, 1'b1);
      check("rd_rdata", d_rdata, 32'hCAFE_F00D);
      check("rd_fetch_gnt", if_gnt, 1'b1);
      drain();

      // Reset in WAIT of a fetch; no completion afterwards, tie goes to fetch.
      n_if_req  = 1'b1;
      n_if_addr = 32'h20;
      step();
      n_if_req = 1'b0;
      repeat (2) step();
      do_reset("rst_wait");
      repeat (RESP_OFS + 1) step();
      n_if_req = 1'b1;
      n_d_req  = 1'b1;
      step();
      check("rw_tie_if", if_gnt, 1'b1);
      check("rw_tie_d", d_gnt, 1'b0);
      drain();

      // Late data request during WAIT of a fetch: granted in RESP.
      n_if_req = 1'b1;
      step();
      n_if_req = 1'b0;
      repeat (2) step();
      n_d_req  = 1'b1;
      n_d_we   = 4'b0011;
      n_d_addr = 32'h300;
      repeat (RESP_OFS - 2) step();
      check("late_d_gnt", d_gnt, 1'b1);
      drain();

      // Randomized traffic with one mid-run reset.
      rand_mode = 1'b1;
      repeat (1500) step();
      do_reset("rst_rand");
      repeat (1500) step();
      rand_mode = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
